read_prefetch_buffer: RTL and testbench

READ_PREFETCH_BUFFER -- requirements
Module: read_prefetch_buffer

---
 rtl/read_buf_pkg.sv | 19 +
 rtl/strobe_sync.sv | 35 +++
 rtl/read_prefetch_buffer.sv | 187 ++++++++++++++++++
 tb/tb_read_prefetch_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/read_buf_pkg.sv
// Shared definitions for the read prefetch buffer.
// Holds the control FSM state encoding and the default parameter values
// used by read_prefetch_buffer.
package read_buf_pkg;

    localparam int WORD_W_DEF     = 16;
    localparam int BYTE_W_DEF     = 8;
    localparam int DEPTH_DEF      = 4;
    localparam int ROW_W_DEF      = 13;
    localparam int START_ROWS_DEF = 3;

    // Binary-encoded control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/strobe_sync.sv
// Brings the asynchronous consumer strobe into the CLK_48MHZ domain and
// turns each rising edge into a single-cycle pulse.
// Ports:
//   CLK_48MHZ  in   system clock
//   RESET      in   asynchronous, active-low reset
//   d          in   asynchronous strobe
//   pulse      out  one-cycle pulse per rising edge of d
// Timing: a rising edge sampled by s0 on clock edge N produces pulse high
// after clock edge N+2 (two sync flops plus a registered edge detect).
module strobe_sync (
    input  logic CLK_48MHZ,
    input  logic RESET,
    input  logic d,
    output logic pulse
);

    logic s0;
    logic s1;
    logic s2;

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            s0    <= 1'b0;
            s1    <= 1'b0;
            s2    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s0    <= d;
            s1    <= s0;
            s2    <= s1;
            pulse <= s1 & ~s2;
        end
    end

endmodule

// File: rtl/read_prefetch_buffer.sv
// Word-to-byte read prefetch buffer.
// Once the writer has produced START_ROWS rows, the buffer fetches memory
// words one request at a time into a DEPTH-word FIFO. After the FIFO first
// fills, each consumer strobe delivers the next byte (LS byte first).
// Ports:
//   CLK_48MHZ   in   system clock
//   RESET       in   asynchronous, active-low reset
//   NEXT_BYTE   in   asynchronous consumer strobe, one byte per rising edge
//   DATA_READ   in   memory read data (WORD_W)
//   DATA_VALID  in   one-cycle strobe qualifying DATA_READ
//   ROW_WRITE   in   rows written so far by the writer (unsigned)
//   READ_CMD    out  word request, high until DATA_VALID
//   BYTE_OUT    out  most recently delivered byte
//   BYTE_STB    out  one-cycle pulse when BYTE_OUT updates
//   UNDERRUN    out  sticky: byte requested while FIFO was empty
//   LEVEL       out  words currently held in the FIFO
//   fsm_state   out  current control state (debug visibility)
// Memory handshake: READ_CMD is the outstanding-request flag. It rises only
// when no request is outstanding and there is room for one more word, stays
// high until a cycle with DATA_VALID=1 (that cycle's DATA_READ is captured),
// and is low the following cycle. DATA_VALID while READ_CMD=0 is ignored.
module read_prefetch_buffer
    import read_buf_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int BYTE_W     = BYTE_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ROW_W      = ROW_W_DEF,
    parameter int START_ROWS = START_ROWS_DEF
) (
    input  logic                       CLK_48MHZ,
    input  logic                       RESET,
    input  logic                       NEXT_BYTE,
    input  logic [WORD_W-1:0]          DATA_READ,
    input  logic                       DATA_VALID,
    input  logic [ROW_W-1:0]           ROW_WRITE,
    output logic                       READ_CMD,
    output logic [BYTE_W-1:0]          BYTE_OUT,
    output logic                       BYTE_STB,
    output logic                       UNDERRUN,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic [1:0]                 fsm_state
);

    localparam int BPW   = WORD_W / BYTE_W;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    state_t              state_q;
    state_t              state_d;
    logic                read_cmd_q;
    logic [IDX_W-1:0]    idx_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [BYTE_W-1:0]   byte_q;
    logic                stb_q;
    logic                underrun_q;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                nb_pulse;
    logic                do_push;
    logic                do_pop;
    logic                do_deliver;
    logic                do_underrun;
    logic                req_issue;
    logic [WORD_W-1:0]   head_word;
    logic [BYTE_W-1:0]   head_byte;

    strobe_sync u_sync (
        .CLK_48MHZ (CLK_48MHZ),
        .RESET     (RESET),
        .d         (NEXT_BYTE),
        .pulse     (nb_pulse)
    );

    assign head_word = mem[rd_ptr_q];
    assign head_byte = head_word[idx_q*BYTE_W +: BYTE_W];

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_d     = state_q;
        do_push     = read_cmd_q & DATA_VALID;
        do_pop      = 1'b0;
        do_deliver  = 1'b0;
        do_underrun = 1'b0;
        // The outstanding request counts against capacity, so with one
        // already in flight no new request may start.
        req_issue   = !read_cmd_q && (state_q != ST_IDLE) && (level_q < FULL_LVL);

        case (state_q)
            ST_IDLE: begin
                if (ROW_WRITE >= ROW_W'(START_ROWS)) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (level_q == FULL_LVL) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (nb_pulse) begin
                    if (level_q != '0) begin
                        do_deliver = 1'b1;
                        do_pop     = (idx_q == LAST_IDX);
                    end else begin
                        do_underrun = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request flag, pointers, level and byte output.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            read_cmd_q <= 1'b0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            byte_q     <= '0;
            stb_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                read_cmd_q <= 1'b0;
            end else if (req_issue) begin
                read_cmd_q <= 1'b1;
            end

            stb_q <= do_deliver;
            if (do_deliver) begin
                byte_q <= head_byte;
                idx_q  <= do_pop ? '0 : idx_q + IDX_W'(1);
            end

            if (do_underrun) begin
                underrun_q <= 1'b1;
            end

            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end

            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Word storage is left unreset; only pointers and level define content.
    always_ff @(posedge CLK_48MHZ) begin
        if (do_push) begin
            mem[wr_ptr_q] <= DATA_READ;
        end
    end

    assign READ_CMD  = read_cmd_q;
    assign BYTE_OUT  = byte_q;
    assign BYTE_STB  = stb_q;
    assign UNDERRUN  = underrun_q;
    assign LEVEL     = level_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_read_prefetch_buffer.sv
`timescale 1ns/1ps
module tb_read_prefetch_buffer;
  import read_buf_pkg::*;

  logic        CLK_48MHZ;
  logic        RESET;
  logic        NEXT_BYTE;
  logic [15:0] DATA_READ;
  logic        DATA_VALID;
  logic [12:0] ROW_WRITE;
  logic        READ_CMD;
  logic [7:0]  BYTE_OUT;
  logic        BYTE_STB;
  logic        UNDERRUN;
  logic [2:0]  LEVEL;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  read_prefetch_buffer dut (
    .CLK_48MHZ  (CLK_48MHZ),
    .RESET      (RESET),
    .NEXT_BYTE  (NEXT_BYTE),
    .DATA_READ  (DATA_READ),
    .DATA_VALID (DATA_VALID),
    .ROW_WRITE  (ROW_WRITE),
    .READ_CMD   (READ_CMD),
    .BYTE_OUT   (BYTE_OUT),
    .BYTE_STB   (BYTE_STB),
    .UNDERRUN   (UNDERRUN),
    .LEVEL      (LEVEL),
    .fsm_state  (fsm_state)
  );

  // clock / reset block
  initial begin
    CLK_48MHZ = 1'b0;
    forever #10 CLK_48MHZ = ~CLK_48MHZ;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  // scoreboard monitor: compares every delivered byte against the queue
  initial begin
    forever begin
      @(posedge CLK_48MHZ);
      #1;
      if (BYTE_STB === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, BYTE_OUT}, 32'hFFFF_FFFF);
        end else begin
          check("byte_out", {24'd0, BYTE_OUT}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic give_word(input logic [15:0] w);
    int waited = 0;
    while (READ_CMD !== 1'b1 && waited < 50) begin
      @(negedge CLK_48MHZ);
      waited++;
    end
    check("read_cmd_wait", {31'd0, READ_CMD}, 32'd1);
    DATA_READ  = w;
    DATA_VALID = 1'b1;
    @(negedge CLK_48MHZ);
    DATA_VALID = 1'b0;
  endtask

  task automatic nb_edge();
    NEXT_BYTE = 1'b1;
    repeat (4) @(negedge CLK_48MHZ);
    NEXT_BYTE = 1'b0;
    repeat (3) @(negedge CLK_48MHZ);
  endtask

  initial begin
    int bad;
    logic [7:0] tail_bytes [6];
    logic [7:0] drain_bytes [4];
    tail_bytes  = '{8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
    drain_bytes = '{8'h65, 8'h87, 8'hA9, 8'hCB};

    RESET = 1'b0; NEXT_BYTE = 1'b0; DATA_READ = '0; DATA_VALID = 1'b0; ROW_WRITE = '0;
    repeat (3) @(negedge CLK_48MHZ);
    check("rst_read_cmd", {31'd0, READ_CMD}, 32'd0);
    check("rst_byte_out", {24'd0, BYTE_OUT}, 32'd0);
    check("rst_byte_stb", {31'd0, BYTE_STB}, 32'd0);
    check("rst_underrun", {31'd0, UNDERRUN}, 32'd0);
    check("rst_level",    {29'd0, LEVEL},    32'd0);
    check("rst_state",    {30'd0, fsm_state}, {30'd0, ST_IDLE});
    RESET = 1'b1;

    // below threshold: no requests
    ROW_WRITE = 13'd2;
    bad = 0;
    repeat (100) begin
      @(negedge CLK_48MHZ);
      if (READ_CMD !== 1'b0) bad++;
    end
    check("idle_no_read_cmd", bad, 0);
    ROW_WRITE = 13'd3;
    repeat (2) @(negedge CLK_48MHZ);
    check("read_cmd_after_start", {31'd0, READ_CMD}, 32'd1);

    // initial fill
    give_word(16'h1234);
    give_word(16'h5678);
    give_word(16'h9ABC);
    give_word(16'hDEF0);
    check("fill_level", {29'd0, LEVEL}, 32'd4);
    @(negedge CLK_48MHZ);
    check("state_run", {30'd0, fsm_state}, {30'd0, ST_RUN});
    bad = 0;
    repeat (10) begin
      @(negedge CLK_48MHZ);
      if (READ_CMD !== 1'b0) bad++;
    end
    check("full_no_read_cmd", bad, 0);

    // byte 1 with latency check
    exp_q.push_back(8'h34);
    NEXT_BYTE = 1'b1;
    repeat (3) @(negedge CLK_48MHZ);
    check("latency_not_early", {31'd0, BYTE_STB}, 32'd0);
    @(negedge CLK_48MHZ);
    check("latency_on_time", {31'd0, BYTE_STB}, 32'd1);
    check("level_after_b1", {29'd0, LEVEL}, 32'd4);
    NEXT_BYTE = 1'b0;
    repeat (3) @(negedge CLK_48MHZ);

    // byte 2 pops the head word; request follows one cycle later
    exp_q.push_back(8'h12);
    NEXT_BYTE = 1'b1;
    repeat (4) @(negedge CLK_48MHZ);
    check("level_after_pop", {29'd0, LEVEL}, 32'd3);
    check("read_cmd_pop_cycle", {31'd0, READ_CMD}, 32'd0);
    @(negedge CLK_48MHZ);
    check("read_cmd_after_pop", {31'd0, READ_CMD}, 32'd1);
    NEXT_BYTE = 1'b0;
    repeat (3) @(negedge CLK_48MHZ);

    // memory withholds: drain, then one extra strobe underruns
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(tail_bytes[i]);
      nb_edge();
    end
    check("no_underrun_yet", {31'd0, UNDERRUN}, 32'd0);
    check("level_drained", {29'd0, LEVEL}, 32'd0);
    nb_edge();
    check("underrun_set", {31'd0, UNDERRUN}, 32'd1);
    check("byte_hold", {24'd0, BYTE_OUT}, 32'h0000_00DE);
    check("read_cmd_held", {31'd0, READ_CMD}, 32'd1);

    // push coinciding with a pop
    give_word(16'h4321);
    give_word(16'h8765);
    check("level_two", {29'd0, LEVEL}, 32'd2);
    repeat (2) @(negedge CLK_48MHZ);
    exp_q.push_back(8'h21);
    nb_edge();
    exp_q.push_back(8'h43);
    NEXT_BYTE = 1'b1;
    repeat (3) @(negedge CLK_48MHZ);
    check("read_cmd_before_coincide", {31'd0, READ_CMD}, 32'd1);
    DATA_READ  = 16'hCBA9;
    DATA_VALID = 1'b1;
    @(negedge CLK_48MHZ);
    DATA_VALID = 1'b0;
    check("level_coincide", {29'd0, LEVEL}, 32'd2);
    NEXT_BYTE = 1'b0;
    repeat (3) @(negedge CLK_48MHZ);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(drain_bytes[i]);
      nb_edge();
    end
    check("level_after_drain2", {29'd0, LEVEL}, 32'd0);
    check("underrun_sticky", {31'd0, UNDERRUN}, 32'd1);

    // reset during an outstanding request
    check("read_cmd_outstanding", {31'd0, READ_CMD}, 32'd1);
    ROW_WRITE = '0;
    RESET = 1'b0;
    #1;
    check("arst_read_cmd", {31'd0, READ_CMD}, 32'd0);
    check("arst_byte_out", {24'd0, BYTE_OUT}, 32'd0);
    check("arst_byte_stb", {31'd0, BYTE_STB}, 32'd0);
    check("arst_underrun", {31'd0, UNDERRUN}, 32'd0);
    check("arst_level",    {29'd0, LEVEL},    32'd0);
    check("arst_state",    {30'd0, fsm_state}, {30'd0, ST_IDLE});
    @(negedge CLK_48MHZ);
    RESET = 1'b1;
    @(negedge CLK_48MHZ);
    DATA_READ  = 16'hFFFF;
    DATA_VALID = 1'b1;
    @(negedge CLK_48MHZ);
    DATA_VALID = 1'b0;
    check("late_dv_level", {29'd0, LEVEL}, 32'd0);
    check("late_dv_read_cmd", {31'd0, READ_CMD}, 32'd0);
    repeat (3) @(negedge CLK_48MHZ);
    check("late_dv_level_hold", {29'd0, LEVEL}, 32'd0);

    check("exp_q_empty", exp_q.size(), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
